// File: rtl/fp_wb_scoreboard.sv
// FP register file controller: round-robin arbitration of result sources onto the single
// register-file write port, plus a 32-entry busy scoreboard that stalls issue on RAW/WAW hazards.
module fp_wb_scoreboard #(
   parameter int NUM_WB = 3,
   parameter int DATA_W = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     issue_valid_i,
   input  logic [4:0]               issue_rd_i,
   input  logic                     issue_rd_we_i,
   input  logic [14:0]              issue_rs_i,
   input  logic [2:0]               issue_rs_used_i,
   output logic                     issue_stall_o,
   input  logic [NUM_WB-1:0]        wb_valid_i,
   input  logic [NUM_WB*5-1:0]      wb_rd_i,
   input  logic [NUM_WB*DATA_W-1:0] wb_data_i,
   output logic [NUM_WB-1:0]        wb_ready_o,
   output logic                     Fregwrite_o,
   output logic [4:0]               FRd_o,
   output logic [DATA_W-1:0]        writeback_data_o,
   output logic [31:0]              busy_o
);
   localparam int PTR_W = $clog2(NUM_WB);
   localparam logic [PTR_W:0] NUM_WB_W = (PTR_W+1)'(NUM_WB);

   // Handshake: a requester raises wb_valid_i[n] and holds wb_rd_i/wb_data_i stable until
   // wb_ready_o[n] is seen high; the result is taken on that same rising edge.

   logic [PTR_W-1:0]  ptr_q;
   logic [31:0]       busy_q;
   logic [31:0]       busy_d;
   logic              rs_hit;
   logic              grant_any;
   logic [PTR_W-1:0]  grant_idx;
   logic [PTR_W:0]    sum;
   logic [PTR_W-1:0]  cand;
   logic [4:0]        wb_rd_arr   [NUM_WB];
   logic [DATA_W-1:0] wb_data_arr [NUM_WB];
   logic [4:0]        rs_arr      [3];

   for (genvar g = 0; g < NUM_WB; g++) begin : g_wb_unpack
      assign wb_rd_arr[g]   = wb_rd_i[g*5 +: 5];
      assign wb_data_arr[g] = wb_data_i[g*DATA_W +: DATA_W];
   end

   for (genvar k = 0; k < 3; k++) begin : g_rs_unpack
      assign rs_arr[k] = issue_rs_i[k*5 +: 5];
   end

   always_comb begin
      rs_hit = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (issue_rs_used_i[k] && busy_q[rs_arr[k]]) rs_hit = 1'b1;
      end
      issue_stall_o = issue_valid_i & (rs_hit | (issue_rd_we_i & busy_q[issue_rd_i]));
   end

   // Search starts one past the last winner, so the previous winner is checked last.
   always_comb begin
      grant_any  = 1'b0;
      grant_idx  = ptr_q;
      wb_ready_o = '0;
      sum        = '0;
      cand       = '0;
      for (int i = 1; i <= NUM_WB; i++) begin
         sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
         if (sum >= NUM_WB_W) sum = sum - NUM_WB_W;
         cand = sum[PTR_W-1:0];
         if (!grant_any && wb_valid_i[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
      if (grant_any) wb_ready_o[grant_idx] = 1'b1;
   end

   // Set is applied after clear so a same-cycle collision leaves the bit set.
   always_comb begin
      busy_d = busy_q;
      if (Fregwrite_o) busy_d[FRd_o] = 1'b0;
      if (issue_valid_i && !issue_stall_o && issue_rd_we_i) busy_d[issue_rd_i] = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q           <= '0;
         ptr_q            <= PTR_W'(NUM_WB - 1);
         Fregwrite_o      <= 1'b0;
         FRd_o            <= '0;
         writeback_data_o <= '0;
      end else begin
         busy_q      <= busy_d;
         Fregwrite_o <= grant_any;
         if (grant_any) begin
            FRd_o            <= wb_rd_arr[grant_idx];
            writeback_data_o <= wb_data_arr[grant_idx];
            ptr_q            <= grant_idx;
         end
      end
   end

   assign busy_o = busy_q;

endmodule

// File: tb/tb_fp_wb_scoreboard.sv
// Self-checking bench for fp_wb_scoreboard: directed hazard/arbitration scenarios plus a
// randomized run checked against a behavioural scoreboard model.
module tb_fp_wb_scoreboard;
   localparam int NUM_WB = 3;
   localparam int DATA_W = 32;

   logic                     clk_i = 1'b0;
   logic                     rst_ni;
   logic                     issue_valid;
   logic [4:0]               issue_rd;
   logic                     issue_rd_we;
   logic [14:0]              issue_rs;
   logic [2:0]               issue_rs_used;
   logic                     issue_stall_o;
   logic [NUM_WB-1:0]        wb_valid;
   logic [NUM_WB*5-1:0]      wb_rd;
   logic [NUM_WB*DATA_W-1:0] wb_data;
   logic [NUM_WB-1:0]        wb_ready_o;
   logic                     Fregwrite_o;
   logic [4:0]               FRd_o;
   logic [DATA_W-1:0]        writeback_data_o;
   logic [31:0]              busy_o;

   fp_wb_scoreboard #(.NUM_WB(NUM_WB), .DATA_W(DATA_W)) dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .issue_valid_i    (issue_valid),
      .issue_rd_i       (issue_rd),
      .issue_rd_we_i    (issue_rd_we),
      .issue_rs_i       (issue_rs),
      .issue_rs_used_i  (issue_rs_used),
      .issue_stall_o    (issue_stall_o),
      .wb_valid_i       (wb_valid),
      .wb_rd_i          (wb_rd),
      .wb_data_i        (wb_data),
      .wb_ready_o       (wb_ready_o),
      .Fregwrite_o      (Fregwrite_o),
      .FRd_o            (FRd_o),
      .writeback_data_o (writeback_data_o),
      .busy_o           (busy_o)
   );

   // clock / reset
   always #5 clk_i = ~clk_i;

   // reference model state
   logic [31:0]     m_busy;
   int              m_ptr;
   bit              m_fw;
   logic [36:0]     exp_wr;
   logic [36:0]     exp_q[$];
   logic [31:0]     rf[32];
   int              errors = 0;
   int              checks = 0;

   function automatic int model_grant();
      for (int i = 1; i <= NUM_WB; i++) begin
         int idx;
         idx = (m_ptr + i) % NUM_WB;
         if (wb_valid[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic bit model_stall();
      if (!issue_valid) return 1'b0;
      for (int k = 0; k < 3; k++)
         if (issue_rs_used[k] && m_busy[issue_rs[k*5 +: 5]]) return 1'b1;
      if (issue_rd_we && m_busy[issue_rd]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [NUM_WB-1:0] model_ready();
      int g;
      logic [NUM_WB-1:0] r;
      r = '0;
      g = model_grant();
      if (g >= 0) r[g] = 1'b1;
      return r;
   endfunction

   // driver tasks
   task automatic idle();
      issue_valid = 1'b0; issue_rd = '0; issue_rd_we = 1'b0;
      issue_rs = '0; issue_rs_used = '0; wb_valid = '0;
   endtask

   task automatic model_reset();
      m_busy = '0; m_ptr = NUM_WB - 1; m_fw = 1'b0; exp_wr = '0;
      exp_q.delete();
   endtask

   // Advance one clock; the model follows the same edge. Called at posedge+1 with inputs set.
   task automatic tick(output int g);
      logic [31:0] nb;
      bit st;
      #1;
      g  = model_grant();
      st = model_stall();
      nb = m_busy;
      if (m_fw) nb[exp_wr[36:32]] = 1'b0;
      if (issue_valid && !st && issue_rd_we) nb[issue_rd] = 1'b1;
      if (g >= 0) begin
         exp_q.push_back({wb_rd[g*5 +: 5], wb_data[g*DATA_W +: DATA_W]});
         m_ptr = g;
      end
      if (Fregwrite_o) rf[FRd_o] = writeback_data_o;
      @(posedge clk_i);
      m_busy = nb;
      m_fw   = (g >= 0);
      if (m_fw) exp_wr = exp_q.pop_front();
      #1;
   endtask

   task automatic apply_reset();
      idle();
      rst_ni = 1'b0;
      model_reset();
      @(posedge clk_i);
      @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_wb(input int r, input logic [4:0] rd, input logic [31:0] d);
      wb_valid[r] = 1'b1;
      wb_rd[r*5 +: 5] = rd;
      wb_data[r*DATA_W +: DATA_W] = d;
   endtask

   task automatic test_reset();
      int g;
      for (int r = 8; r < 12; r++) begin
         issue_valid = 1'b1; issue_rd = 5'(r); issue_rd_we = 1'b1;
         if (r == 11) set_wb(0, 5'd20, 32'hCAFE_0001);
         tick(g);
      end
      idle();
      #1;
      checks++; if (busy_o !== 32'h0000_0F00) begin errors++; $display("FAIL reset_pre_busy: got %h expected %h", busy_o, 32'h0000_0F00); end
      checks++; if (Fregwrite_o !== 1'b1) begin errors++; $display("FAIL reset_pre_wr: got %b expected 1", Fregwrite_o); end
      #1;
      rst_ni = 1'b0;
      model_reset();
      #1;
      checks++; if (busy_o !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h expected 0", busy_o); end
      checks++; if (Fregwrite_o !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b expected 0", Fregwrite_o); end
      checks++; if (FRd_o !== 5'd0 || writeback_data_o !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h/%h expected 0/0", FRd_o, writeback_data_o); end
      @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      checks++; if (busy_o !== 32'h0 || Fregwrite_o !== 1'b0) begin errors++; $display("FAIL reset_after: got busy=%h wr=%b expected 0/0", busy_o, Fregwrite_o); end
   endtask

   task automatic test_raw();
      int g;
      logic [31:0] d;
      d = $urandom();
      issue_valid = 1'b1; issue_rd = 5'd5; issue_rd_we = 1'b1;
      #1;
      checks++; if (issue_stall_o !== 1'b0) begin errors++; $display("FAIL raw_first: got %b expected 0", issue_stall_o); end
      tick(g);
      issue_rd = 5'd0; issue_rd_we = 1'b0; issue_rs = {10'd0, 5'd5}; issue_rs_used = 3'b001;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++; if (issue_stall_o !== 1'b1) begin errors++; $display("FAIL raw_stall: got %b expected 1", issue_stall_o); end
         tick(g);
      end
      set_wb(1, 5'd5, d);
      #1;
      checks++; if (wb_ready_o !== 3'b010) begin errors++; $display("FAIL raw_ready: got %b expected 010", wb_ready_o); end
      tick(g);
      wb_valid = '0;
      #1;
      checks++; if (Fregwrite_o !== 1'b1 || FRd_o !== 5'd5 || writeback_data_o !== d) begin errors++; $display("FAIL raw_write: got %b/%0d/%h expected 1/5/%h", Fregwrite_o, FRd_o, writeback_data_o, d); end
      checks++; if (issue_stall_o !== 1'b1) begin errors++; $display("FAIL raw_stall_wr_cycle: got %b expected 1", issue_stall_o); end
      tick(g);
      checks++; if (issue_stall_o !== 1'b0 || busy_o[5] !== 1'b0) begin errors++; $display("FAIL raw_release: got stall=%b busy5=%b expected 0/0", issue_stall_o, busy_o[5]); end
      checks++; if (rf[5] !== d) begin errors++; $display("FAIL raw_operand: got %h expected %h", rf[5], d); end
      tick(g);
      idle();
   endtask

   task automatic test_waw();
      int g;
      issue_valid = 1'b1; issue_rd = 5'd3; issue_rd_we = 1'b1;
      tick(g);
      #1;
      checks++; if (issue_stall_o !== 1'b1) begin errors++; $display("FAIL waw_stall: got %b expected 1", issue_stall_o); end
      issue_rd_we = 1'b0; issue_rs = {5'd3, 5'd3, 5'd3}; issue_rs_used = 3'b000;
      #1;
      checks++; if (issue_stall_o !== 1'b0) begin errors++; $display("FAIL waw_unused_rs: got %b expected 0", issue_stall_o); end
      issue_rs_used = 3'b100;
      #1;
      checks++; if (issue_stall_o !== 1'b1) begin errors++; $display("FAIL waw_rs3_used: got %b expected 1", issue_stall_o); end
      issue_valid = 1'b0;
      #1;
      checks++; if (issue_stall_o !== 1'b0) begin errors++; $display("FAIL waw_no_valid: got %b expected 0", issue_stall_o); end
      idle();
      set_wb(2, 5'd3, 32'h3333_0000);
      tick(g);
      wb_valid = '0;
      tick(g);
      checks++; if (busy_o !== 32'h0) begin errors++; $display("FAIL waw_clear: got %h expected 0", busy_o); end
   endtask

   task automatic test_rr();
      int g;
      logic [31:0] d[3];
      apply_reset();
      for (int r = 0; r < 3; r++) begin
         d[r] = $urandom();
         set_wb(r, 5'(20 + r), d[r]);
      end
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (wb_ready_o !== 3'(1 << i)) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", i, wb_ready_o, 3'(1 << i)); end
         if (i > 0) begin
            checks++; if (Fregwrite_o !== 1'b1 || FRd_o !== 5'(19 + i) || writeback_data_o !== d[i-1]) begin errors++; $display("FAIL rr_write%0d: got %b/%0d/%h expected 1/%0d/%h", i - 1, Fregwrite_o, FRd_o, writeback_data_o, 19 + i, d[i-1]); end
         end
         tick(g);
         wb_valid[i] = 1'b0;
      end
      #1;
      checks++; if (Fregwrite_o !== 1'b1 || FRd_o !== 5'd22 || writeback_data_o !== d[2]) begin errors++; $display("FAIL rr_write2: got %b/%0d/%h expected 1/22/%h", Fregwrite_o, FRd_o, writeback_data_o, d[2]); end
      tick(g);
      checks++; if (Fregwrite_o !== 1'b0 || FRd_o !== 5'd22) begin errors++; $display("FAIL rr_idle_hold: got %b/%0d expected 0/22", Fregwrite_o, FRd_o); end
   endtask

   task automatic test_wrap();
      int g;
      set_wb(0, 5'd12, 32'h1200_0000);
      set_wb(2, 5'd13, 32'h1300_0000);
      #1;
      checks++; if (wb_ready_o !== 3'b001) begin errors++; $display("FAIL wrap_grant0: got %b expected 001", wb_ready_o); end
      tick(g);
      set_wb(0, 5'd14, 32'h1400_0000);
      #1;
      checks++; if (wb_ready_o !== 3'b100) begin errors++; $display("FAIL wrap_grant2: got %b expected 100", wb_ready_o); end
      tick(g);
      wb_valid[2] = 1'b0;
      #1;
      checks++; if (wb_ready_o !== 3'b001) begin errors++; $display("FAIL wrap_grant0b: got %b expected 001", wb_ready_o); end
      tick(g);
      idle();
      #1;
      checks++; if (wb_ready_o !== 3'b000) begin errors++; $display("FAIL wrap_none: got %b expected 000", wb_ready_o); end
      tick(g);
   endtask

   task automatic test_same_cycle();
      int g;
      issue_valid = 1'b1; issue_rd = 5'd7; issue_rd_we = 1'b1;
      tick(g);
      idle();
      set_wb(2, 5'd7, 32'h7777_7777);
      tick(g);
      wb_valid = '0;
      issue_valid = 1'b1; issue_rd = 5'd9; issue_rd_we = 1'b1;
      issue_rs = {5'd7, 5'd7, 5'd7}; issue_rs_used = 3'b000;
      #1;
      checks++; if (Fregwrite_o !== 1'b1 || FRd_o !== 5'd7 || issue_stall_o !== 1'b0) begin errors++; $display("FAIL same_pre: got wr=%b rd=%0d stall=%b expected 1/7/0", Fregwrite_o, FRd_o, issue_stall_o); end
      tick(g);
      idle();
      checks++; if (busy_o[7] !== 1'b0 || busy_o[9] !== 1'b1) begin errors++; $display("FAIL same_post: got b7=%b b9=%b expected 0/1", busy_o[7], busy_o[9]); end
      set_wb(1, 5'd9, 32'h9999_9999);
      tick(g);
      wb_valid = '0;
      tick(g);
   endtask

   task automatic test_random();
      int g;
      for (int c = 0; c < 400; c++) begin
         for (int r = 0; r < NUM_WB; r++) begin
            if (!wb_valid[r] && $urandom_range(0, 2) == 0) begin
               logic [4:0] rd;
               rd = 5'($urandom_range(0, 7));
               if (m_busy[7:0] != 8'h0 && $urandom_range(0, 3) != 0)
                  for (int t = 0; t < 16 && !m_busy[rd]; t++) rd = 5'($urandom_range(0, 7));
               set_wb(r, rd, $urandom());
            end
         end
         issue_valid   = ($urandom_range(0, 9) < 7);
         issue_rd      = 5'($urandom_range(0, 7));
         issue_rd_we   = 1'($urandom_range(0, 1));
         issue_rs      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         issue_rs_used = 3'($urandom_range(0, 7));
         #1;
         checks++; if (issue_stall_o !== model_stall()) begin errors++; $display("FAIL rnd_stall c%0d: got %b expected %b", c, issue_stall_o, model_stall()); end
         checks++; if (wb_ready_o !== model_ready()) begin errors++; $display("FAIL rnd_ready c%0d: got %b expected %b", c, wb_ready_o, model_ready()); end
         checks++; if (busy_o !== m_busy) begin errors++; $display("FAIL rnd_busy c%0d: got %h expected %h", c, busy_o, m_busy); end
         checks++; if (Fregwrite_o !== m_fw) begin errors++; $display("FAIL rnd_wr c%0d: got %b expected %b", c, Fregwrite_o, m_fw); end
         if (m_fw) begin
            checks++; if ({FRd_o, writeback_data_o} !== exp_wr) begin errors++; $display("FAIL rnd_wdata c%0d: got %h expected %h", c, {FRd_o, writeback_data_o}, exp_wr); end
         end
         tick(g);
         if (g >= 0) wb_valid[g] = 1'b0;
      end
      idle();
   endtask

   initial begin
      idle();
      wb_rd = '0;
      wb_data = '0;
      model_reset();
      rst_ni = 1'b0;
      #3;
      checks++; if (busy_o !== 32'h0 || Fregwrite_o !== 1'b0 || issue_stall_o !== 1'b0) begin errors++; $display("FAIL por: got busy=%h wr=%b stall=%b expected 0/0/0", busy_o, Fregwrite_o, issue_stall_o); end
      @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      test_reset();
      test_raw();
      test_waw();
      test_rr();
      test_wrap();
      test_same_cycle();
      apply_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
